// File: rtl/ltc2mc_pkg.sv
// Shared widths, FSM state type and request record for the LTC-to-LPDDR2 bridge.
package ltc2mc_pkg;
  localparam int unsigned AVL_ADDR_W = 25;
  localparam int unsigned AVL_DATA_W = 128;
  localparam int unsigned AVL_BE_W   = 16;
  localparam int unsigned AVL_SIZE_W = 5;
  localparam logic [AVL_SIZE_W-1:0] AVL_BURST_SIZE = 5'd1;
  // Widest LTC tag the request record can carry; TAG_W must not exceed this.
  localparam int unsigned TAG_MAX_W = 16;

  typedef enum logic {
    WAIT_MC = 1'b0,
    RUN     = 1'b1
  } ltc2mc_state_t;

  typedef struct packed {
    logic                  we;
    logic [AVL_ADDR_W-1:0] addr;
    logic [TAG_MAX_W-1:0]  tag;
    logic [AVL_DATA_W-1:0] wdata;
    logic [AVL_BE_W-1:0]   be;
  } ltc2mc_req_t;
endpackage

// File: rtl/ltc2mc_tag_fifo.sv
// In-order FIFO of outstanding read tags; pointers wrap modulo DEPTH (power of two).
module ltc2mc_tag_fifo #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // Tag storage; contents need no reset since count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ltc2mc_bridge.sv
// LTC request bridge onto LPDDR2 controller Avalon port 0: one registered command,
// single-beat bursts, in-order read tag tracking and registered read responses.
// Optional statistics counters: define LTC2MC_BRIDGE_STATS_EN.
module ltc2mc_bridge
  import ltc2mc_pkg::*;
#(
  parameter int unsigned TAG_W           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clkrst_mem_clk,
  input  logic                  clkrst_mem_rst,
  input  logic                  mc_ready,
  input  logic                  ltc_req_valid,
  output logic                  ltc_req_ready,
  input  logic                  ltc_req_we,
  input  logic [AVL_ADDR_W-1:0] ltc_req_addr,
  input  logic [TAG_W-1:0]      ltc_req_tag,
  input  logic [AVL_DATA_W-1:0] ltc_req_wdata,
  input  logic [AVL_BE_W-1:0]   ltc_req_be,
  output logic                  ltc_rsp_valid,
  output logic [TAG_W-1:0]      ltc_rsp_tag,
  output logic [AVL_DATA_W-1:0] ltc_rsp_rdata,
  output logic [AVL_ADDR_W-1:0] ltc2mc_avl_addr_0,
  output logic [AVL_DATA_W-1:0] ltc2mc_avl_wdata_0,
  output logic [AVL_BE_W-1:0]   ltc2mc_avl_be_0,
  output logic [AVL_SIZE_W-1:0] ltc2mc_avl_size_0,
  output logic                  ltc2mc_avl_read_req_0,
  output logic                  ltc2mc_avl_write_req_0,
  output logic                  ltc2mc_avl_burstbegin_0,
  input  logic                  ltc2mc_avl_ready_0,
  input  logic                  ltc2mc_avl_rdata_valid_0,
  input  logic [AVL_DATA_W-1:0] ltc2mc_avl_rdata_0,
  output logic                  rsp_err
`ifdef LTC2MC_BRIDGE_STATS_EN
  ,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  ltc2mc_state_t          r_state;
  ltc2mc_state_t          w_state_nxt;
  ltc2mc_req_t            r_cmd;
  ltc2mc_req_t            w_req;
  logic                   r_cmd_valid;
  logic                   w_cmd_fire;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_rd_full_next;
  logic [CNT_W-1:0]       w_rd_cnt;
  logic [CNT_W-1:0]       w_rd_cnt_next;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [TAG_W-1:0]       w_head_tag;
  logic [TAG_MAX_W:0]     w_unused;
  logic                   r_rsp_valid;
  logic [TAG_W-1:0]       r_rsp_tag;
  logic [AVL_DATA_W-1:0]  r_rsp_rdata;
  logic                   r_rsp_err;

  assign w_req.we    = ltc_req_we;
  assign w_req.addr  = ltc_req_addr;
  assign w_req.tag   = TAG_MAX_W'(ltc_req_tag);
  assign w_req.wdata = ltc_req_wdata;
  assign w_req.be    = ltc_req_be;

  assign w_cmd_fire     = r_cmd_valid & ltc2mc_avl_ready_0;
  assign w_push         = w_cmd_fire & ~r_cmd.we;
  assign w_pop          = ltc2mc_avl_rdata_valid_0 & ~w_fifo_empty;
  assign w_rd_cnt_next  = w_rd_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_rd_full_next = (w_rd_cnt_next == CNT_MAX);
  assign w_accept       = ltc_req_valid & ltc_req_ready;
  // Upper tag bits are zero padding; FIFO fullness is tracked through the count.
  assign w_unused       = {r_cmd.tag, w_fifo_full};

  ltc2mc_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .i_clk   (clkrst_mem_clk),
    .i_rst   (clkrst_mem_rst),
    .i_push  (w_push),
    .i_din   (r_cmd.tag[TAG_W-1:0]),
    .i_pop   (w_pop),
    .o_dout  (w_head_tag),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_rd_cnt)
  );

  // State register.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) r_state <= WAIT_MC;
    else                r_state <= w_state_nxt;
  end

  // Next state and LTC ready; RUN is held while a command is pending so it is never retracted.
  always_comb begin
    w_state_nxt   = r_state;
    ltc_req_ready = 1'b0;
    unique case (r_state)
      WAIT_MC: begin
        if (mc_ready) w_state_nxt = RUN;
      end
      RUN: begin
        if (!mc_ready && !r_cmd_valid) w_state_nxt = WAIT_MC;
        ltc_req_ready = mc_ready & (~r_cmd_valid | w_cmd_fire)
                      & ~(~ltc_req_we & w_rd_full_next);
      end
    endcase
  end

  // Single-entry command register, refilled in the same cycle it is accepted downstream.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
    end else if (w_accept) begin
      r_cmd_valid <= 1'b1;
      r_cmd       <= w_req;
    end else if (w_cmd_fire) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Registered read response and sticky error for data with nothing outstanding.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tag   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_tag   <= w_head_tag;
        r_rsp_rdata <= ltc2mc_avl_rdata_0;
      end
      if (ltc2mc_avl_rdata_valid_0 && w_fifo_empty) r_rsp_err <= 1'b1;
    end
  end

  assign ltc2mc_avl_addr_0       = r_cmd.addr;
  assign ltc2mc_avl_wdata_0      = r_cmd.wdata;
  assign ltc2mc_avl_be_0         = r_cmd.be;
  assign ltc2mc_avl_size_0       = AVL_BURST_SIZE;
  assign ltc2mc_avl_read_req_0   = r_cmd_valid & ~r_cmd.we;
  assign ltc2mc_avl_write_req_0  = r_cmd_valid & r_cmd.we;
  assign ltc2mc_avl_burstbegin_0 = r_cmd_valid;
  assign ltc_rsp_valid           = r_rsp_valid;
  assign ltc_rsp_tag             = r_rsp_tag;
  assign ltc_rsp_rdata           = r_rsp_rdata;
  assign rsp_err                 = r_rsp_err;

`ifdef LTC2MC_BRIDGE_STATS_EN
  // Wrapping activity counters: read/write issues and Avalon stall cycles.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (w_push)                          stat_rd_cnt    <= stat_rd_cnt + 1'b1;
      if (w_cmd_fire && r_cmd.we)          stat_wr_cnt    <= stat_wr_cnt + 1'b1;
      if (r_cmd_valid && !ltc2mc_avl_ready_0) stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ltc2mc_bridge.sv
// Directed, table-driven bench for ltc2mc_bridge with hand-written multi-cycle sequences.
module tb_ltc2mc_bridge;
  logic         clk = 1'b0;
  logic         rst;
  logic         mc_ready;
  logic         ltc_req_valid;
  logic         ltc_req_ready;
  logic         ltc_req_we;
  logic [24:0]  ltc_req_addr;
  logic [3:0]   ltc_req_tag;
  logic [127:0] ltc_req_wdata;
  logic [15:0]  ltc_req_be;
  logic         ltc_rsp_valid;
  logic [3:0]   ltc_rsp_tag;
  logic [127:0] ltc_rsp_rdata;
  logic [24:0]  avl_addr;
  logic [127:0] avl_wdata;
  logic [15:0]  avl_be;
  logic [4:0]   avl_size;
  logic         avl_rd;
  logic         avl_wr;
  logic         avl_bb;
  logic         avl_ready;
  logic         avl_rdv;
  logic [127:0] avl_rdata;
  logic         rsp_err;
`ifdef LTC2MC_BRIDGE_STATS_EN
  logic [31:0]  stat_rd_cnt;
  logic [31:0]  stat_wr_cnt;
  logic [31:0]  stat_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  ltc2mc_bridge #(.TAG_W(4), .MAX_OUTSTANDING(8)) dut (
    .clkrst_mem_clk           (clk),
    .clkrst_mem_rst           (rst),
    .mc_ready                 (mc_ready),
    .ltc_req_valid            (ltc_req_valid),
    .ltc_req_ready            (ltc_req_ready),
    .ltc_req_we               (ltc_req_we),
    .ltc_req_addr             (ltc_req_addr),
    .ltc_req_tag              (ltc_req_tag),
    .ltc_req_wdata            (ltc_req_wdata),
    .ltc_req_be               (ltc_req_be),
    .ltc_rsp_valid            (ltc_rsp_valid),
    .ltc_rsp_tag              (ltc_rsp_tag),
    .ltc_rsp_rdata            (ltc_rsp_rdata),
    .ltc2mc_avl_addr_0        (avl_addr),
    .ltc2mc_avl_wdata_0       (avl_wdata),
    .ltc2mc_avl_be_0          (avl_be),
    .ltc2mc_avl_size_0        (avl_size),
    .ltc2mc_avl_read_req_0    (avl_rd),
    .ltc2mc_avl_write_req_0   (avl_wr),
    .ltc2mc_avl_burstbegin_0  (avl_bb),
    .ltc2mc_avl_ready_0       (avl_ready),
    .ltc2mc_avl_rdata_valid_0 (avl_rdv),
    .ltc2mc_avl_rdata_0       (avl_rdata),
    .rsp_err                  (rsp_err)
`ifdef LTC2MC_BRIDGE_STATS_EN
    ,
    .stat_rd_cnt              (stat_rd_cnt),
    .stat_wr_cnt              (stat_wr_cnt),
    .stat_stall_cnt           (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mc, v, we;
    logic [24:0] addr;
    logic [3:0]  tag;
    logic        ardy, rdv;
    logic [31:0] d;
    logic        e_rdy, e_rd, e_wr;
    logic [24:0] e_addr;
    logic        e_rv;
    logic [3:0]  e_tag;
    logic [31:0] e_d;
    logic        e_err;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [127:0] wd(input logic [24:0] a);
    return {4{7'h0, a}};
  endfunction

  function automatic logic [127:0] rd(input logic [31:0] d);
    return {4{d}};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs applied at the falling edge, outputs observed 1 time unit later.
  task automatic drive(input logic mc, input logic v, input logic we, input logic [24:0] a,
                       input logic [3:0] t, input logic ardy, input logic rdv, input logic [31:0] d);
    @(negedge clk);
    mc_ready      = mc;
    ltc_req_valid = v;
    ltc_req_we    = we;
    ltc_req_addr  = a;
    ltc_req_tag   = t;
    ltc_req_wdata = wd(a);
    ltc_req_be    = 16'hFFFF;
    avl_ready     = ardy;
    avl_rdv       = rdv;
    avl_rdata     = rd(d);
    #1;
  endtask

  // Returns n read beats; prev >= 0 is the tag whose response is due in the first cycle.
  task automatic drain(input int n, input int first, input int prev);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 25'h0, 4'h0, 1'b0, 1'b1, 32'hD000_0000 + 32'(first + i));
      if (i > 0 || prev >= 0) begin
        chk1($sformatf("drain_rv%0d", first + i), ltc_rsp_valid, 1'b1);
        chkv($sformatf("drain_tag%0d", first + i), 128'(ltc_rsp_tag),
             (i == 0) ? 128'(prev) : 128'(first + i - 1));
      end
    end
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    chk1("drain_last_rv", ltc_rsp_valid, 1'b1);
    chkv("drain_last_tag", 128'(ltc_rsp_tag), 128'(first + n - 1));
    chkv("drain_last_data", ltc_rsp_rdata, rd(32'hD000_0000 + 32'(first + n - 1)));
  endtask

  initial begin
    // mc,v,we,addr,tag,ardy,rdv,data | rdy,rd,wr,avl_addr,rsp_v,rsp_tag,rsp_data,err
    tbl[0]  = '{1'b1,1'b1,1'b0,25'h10,4'd3,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,25'h0, 1'b0,4'd0,32'h0,        1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,25'h10,4'd3,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,25'h0, 1'b0,4'd0,32'h0,        1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,25'h10,4'd3,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,25'h10,1'b0,4'd0,32'h0,        1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,25'h20,4'd0,1'b1,1'b0,32'h0,        1'b1,1'b1,1'b0,25'h10,1'b0,4'd0,32'h0,        1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,25'h30,4'd5,1'b1,1'b0,32'h0,        1'b1,1'b0,1'b1,25'h20,1'b0,4'd0,32'h0,        1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,25'h30,4'd5,1'b1,1'b1,32'h11111111, 1'b1,1'b1,1'b0,25'h30,1'b0,4'd0,32'h0,        1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b0,25'h30,4'd5,1'b0,1'b1,32'h22222222, 1'b1,1'b0,1'b0,25'h30,1'b1,4'd3,32'h11111111, 1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,25'h30,4'd5,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,25'h30,1'b1,4'd5,32'h22222222, 1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,25'h30,4'd5,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,25'h30,1'b0,4'd0,32'h0,        1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,25'h30,4'd5,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,25'h30,1'b0,4'd0,32'h0,        1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0,25'h40,4'd6,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,25'h30,1'b0,4'd0,32'h0,        1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,25'h40,4'd6,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,25'h30,1'b0,4'd0,32'h0,        1'b0};

    rst = 1'b1;
    mc_ready = 1'b0; ltc_req_valid = 1'b0; ltc_req_we = 1'b0; ltc_req_addr = '0;
    ltc_req_tag = '0; ltc_req_wdata = '0; ltc_req_be = '0;
    avl_ready = 1'b0; avl_rdv = 1'b0; avl_rdata = '0;
    #2;
    chk1("rst_ready", ltc_req_ready, 1'b0);
    chk1("rst_rd", avl_rd, 1'b0);
    chk1("rst_wr", avl_wr, 1'b0);
    chk1("rst_bb", avl_bb, 1'b0);
    chkv("rst_size", 128'(avl_size), 128'd1);
    chkv("rst_addr", 128'(avl_addr), 128'd0);
    chk1("rst_rsp_v", ltc_rsp_valid, 1'b0);
    chk1("rst_err", rsp_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Startup gating: a request held while the controller is not ready.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 25'h10, 4'd3, 1'b1, 1'b0, 32'h0);
      chk1($sformatf("gate_rdy%0d", i), ltc_req_ready, 1'b0);
      chk1($sformatf("gate_rd%0d", i), avl_rd | avl_wr, 1'b0);
    end

    // Table: startup release, basic read/write issue, in-order responses, return to WAIT_MC.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].mc, tbl[i].v, tbl[i].we, tbl[i].addr, tbl[i].tag, tbl[i].ardy, tbl[i].rdv, tbl[i].d);
      chk1($sformatf("t%0d_rdy", i), ltc_req_ready, tbl[i].e_rdy);
      chk1($sformatf("t%0d_rd", i), avl_rd, tbl[i].e_rd);
      chk1($sformatf("t%0d_wr", i), avl_wr, tbl[i].e_wr);
      chkv($sformatf("t%0d_addr", i), 128'(avl_addr), 128'(tbl[i].e_addr));
      chk1($sformatf("t%0d_rsp_v", i), ltc_rsp_valid, tbl[i].e_rv);
      chk1($sformatf("t%0d_err", i), rsp_err, tbl[i].e_err);
      if (tbl[i].e_rv) begin
        chkv($sformatf("t%0d_rsp_tag", i), 128'(ltc_rsp_tag), 128'(tbl[i].e_tag));
        chkv($sformatf("t%0d_rsp_data", i), ltc_rsp_rdata, rd(tbl[i].e_d));
      end
    end

    // Avalon backpressure, including mc_ready dropping under a pending write.
    drive(1'b1, 1'b1, 1'b1, 25'h1ABCDE, 4'd0, 1'b0, 1'b0, 32'h0);
    chk1("bp_accept", ltc_req_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive((i == 2 || i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, 25'h5, 4'd0, 1'b0, 1'b0, 32'h0);
      ltc_req_be = 16'h00F0;
      chk1($sformatf("bp_rdy%0d", i), ltc_req_ready, 1'b0);
      chk1($sformatf("bp_wr%0d", i), avl_wr, 1'b1);
      chk1($sformatf("bp_bb%0d", i), avl_bb, 1'b1);
      chkv($sformatf("bp_addr%0d", i), 128'(avl_addr), 128'h1ABCDE);
      chkv($sformatf("bp_wdata%0d", i), avl_wdata, wd(25'h1ABCDE));
      chkv($sformatf("bp_be%0d", i), 128'(avl_be), 128'hFFFF);
    end
    drive(1'b1, 1'b1, 1'b1, 25'h5, 4'd0, 1'b1, 1'b0, 32'h0);
    ltc_req_be = 16'h00F0;
    chk1("bp_fire_rdy", ltc_req_ready, 1'b1);
    chkv("bp_fire_addr", 128'(avl_addr), 128'h1ABCDE);
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b1, 1'b0, 32'h0);
    chk1("bp2_wr", avl_wr, 1'b1);
    chkv("bp2_addr", 128'(avl_addr), 128'h5);
    chkv("bp2_wdata", avl_wdata, wd(25'h5));
    chkv("bp2_be", 128'(avl_be), 128'h00F0);
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b0, 1'b0, 32'h0);
    chk1("bp_idle_wr", avl_wr, 1'b0);
    chk1("bp_idle_bb", avl_bb, 1'b0);

    // Outstanding limit: eight reads in flight refuse a ninth read but not a write.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, 25'h100 + 25'(k), 4'(k), 1'b1, 1'b0, 32'h0);
      chk1($sformatf("lim_rdy%0d", k), ltc_req_ready, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b0, 25'h108, 4'd8, 1'b1, 1'b0, 32'h0);
    chk1("lim_rd_refused", ltc_req_ready, 1'b0);
    ltc_req_we = 1'b1;
    ltc_req_addr = 25'h200;
    #1;
    chk1("lim_wr_accepted", ltc_req_ready, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 25'h108, 4'd8, 1'b1, 1'b0, 32'h0);
    chk1("lim_rd_still_refused", ltc_req_ready, 1'b0);
    chk1("lim_wr_issue", avl_wr, 1'b1);
    chkv("lim_full_cnt", 128'(dut.w_rd_cnt), 128'd8);
    drive(1'b1, 1'b1, 1'b0, 25'h108, 4'd8, 1'b1, 1'b1, 32'hAAAA_0000);
    chk1("lim_pop_rdy", ltc_req_ready, 1'b1);
    chk1("lim_pop_rsp_v", ltc_rsp_valid, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b0, 1'b0, 32'h0);
    chk1("lim_rsp_v", ltc_rsp_valid, 1'b1);
    chkv("lim_rsp_tag", 128'(ltc_rsp_tag), 128'd0);
    chkv("lim_rsp_data", ltc_rsp_rdata, rd(32'hAAAA_0000));
    chk1("lim_9th_rd", avl_rd, 1'b1);
    chkv("lim_9th_addr", 128'(avl_addr), 128'h108);
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b1, 1'b0, 32'h0);
    drain(8, 1, -1);

    // Simultaneous push and pop with four reads outstanding.
    for (int k = 9; k < 14; k++) drive(1'b1, 1'b1, 1'b0, 25'h300 + 25'(k), 4'(k), 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b1, 1'b1, 32'hD000_0009);
    chkv("pp_cnt_before", 128'(dut.w_rd_cnt), 128'd4);
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b0, 1'b1, 32'hD000_000A);
    chkv("pp_cnt_after", 128'(dut.w_rd_cnt), 128'd4);
    chk1("pp_rsp_v", ltc_rsp_valid, 1'b1);
    chkv("pp_rsp_tag", 128'(ltc_rsp_tag), 128'd9);
    drain(3, 11, 10);

    // Spurious read data with nothing outstanding.
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b0, 1'b1, 32'hBAD0_0000);
    chk1("sp_err_before", rsp_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b0, 1'b0, 32'h0);
      chk1($sformatf("sp_rsp_v%0d", i), ltc_rsp_valid, 1'b0);
      chk1($sformatf("sp_err%0d", i), rsp_err, 1'b1);
    end

    // Reset while three reads are outstanding and a write is pending.
    for (int k = 1; k < 4; k++) drive(1'b1, 1'b1, 1'b0, 25'h400 + 25'(k), 4'(k), 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 25'h77, 4'd0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b0, 1'b0, 32'h0);
    chk1("mr_pending_wr", avl_wr, 1'b1);
    chkv("mr_cnt_pre", 128'(dut.w_rd_cnt), 128'd3);
    rst = 1'b1;
    #1;
    chk1("mr_ready", ltc_req_ready, 1'b0);
    chk1("mr_rd", avl_rd, 1'b0);
    chk1("mr_wr", avl_wr, 1'b0);
    chk1("mr_bb", avl_bb, 1'b0);
    chkv("mr_addr", 128'(avl_addr), 128'd0);
    chkv("mr_wdata", avl_wdata, 128'd0);
    chkv("mr_be", 128'(avl_be), 128'd0);
    chkv("mr_size", 128'(avl_size), 128'd1);
    chk1("mr_rsp_v", ltc_rsp_valid, 1'b0);
    chkv("mr_rsp_tag", 128'(ltc_rsp_tag), 128'd0);
    chkv("mr_rsp_data", ltc_rsp_rdata, 128'd0);
    chk1("mr_err", rsp_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b0, 1'b1, 32'hDEAD_0001);
    chkv("mr_cnt_post", 128'(dut.w_rd_cnt), 128'd0);
    chk1("mr_err_post", rsp_err, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 25'h0, 4'd0, 1'b0, 1'b0, 32'h0);
    chk1("mr_late_rsp_v", ltc_rsp_valid, 1'b0);
    chk1("mr_late_err", rsp_err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
